// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 VGA timing constants shared by the sync generator
//               and the pixel painters.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Both sync pulses are active-low in this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int COORD_W = 10;

endpackage
`default_nettype wire

// File: rtl/pixel_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_div
// Description : Mod-DIV counter producing a one-clk terminal-count enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("pixel_tick_div: DIV must be at least 1");
        end

        if (DIV == 1) begin : g_passthru
            logic w_unused;
            assign w_unused = ^{clk, rst};
            assign tick     = 1'b1;
        end else begin : g_count
            localparam int W = $clog2(DIV);
            localparam logic [W-1:0] C_LAST = W'(DIV - 1);
            localparam logic [W-1:0] C_ONE  = W'(1);

            logic [W-1:0] r_div;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_div <= '0;
                end else if (r_div == C_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + C_ONE;
                end
            end

            assign tick = (r_div == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA h/v timing generator: pixel enable, syncs, visible flag,
//               pixel coordinates and frame-start marker.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int TICK_DIV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               p_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit the coordinate width");
        end
    endgenerate

    localparam logic [COORD_W-1:0] C_H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] C_V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] C_H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] C_V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] C_HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] C_HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] C_VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] C_VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [COORD_W-1:0] C_ONE      = COORD_W'(1);

    logic               w_tick;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic               w_hs_nxt;
    logic               w_vs_nxt;
    logic               w_vo_nxt;
    logic               w_fs_nxt;

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_hs;
    logic               r_vs;
    logic               r_vo;
    logic               r_fs;

    pixel_tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_tick) begin
            if (r_x == C_H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == C_V_LAST) ? '0 : r_y + C_ONE;
            end else begin
                w_x_nxt = r_x + C_ONE;
            end
        end
    end

    // Decoding the next counter values keeps the registered flags aligned
    // with the coordinates they describe.
    always_comb begin
        w_hs_nxt = ((w_x_nxt >= C_HS_FIRST) && (w_x_nxt <= C_HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vs_nxt = ((w_y_nxt >= C_VS_FIRST) && (w_y_nxt <= C_VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vo_nxt = (w_x_nxt < C_H_VIS) && (w_y_nxt < C_V_VIS);
        w_fs_nxt = (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    // Counters start at the last position so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x  <= C_H_LAST;
            r_y  <= C_V_LAST;
            r_hs <= ~SYNC_ACTIVE;
            r_vs <= ~SYNC_ACTIVE;
            r_vo <= 1'b0;
            r_fs <= 1'b0;
        end else begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_hs <= w_hs_nxt;
            r_vs <= w_vs_nxt;
            r_vo <= w_vo_nxt;
            r_fs <= w_fs_nxt;
        end
    end

    assign p_tick      = w_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign video_on    = r_vo;
    assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    typedef struct packed {
        logic       tick;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       pt_a, hs_a, vs_a, vo_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, hs_b, vs_b, vo_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       pt_c, hs_c, vs_c, vo_c, fs_c;
    logic [9:0] x_c, y_c;

    vga_sync_gen u_dut_a (
        .clk(clk), .rst(rst), .p_tick(pt_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(vo_a), .pixel_x(x_a), .pixel_y(y_a), .frame_start(fs_a)
    );

    vga_sync_gen #(.TICK_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .p_tick(pt_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(vo_b), .pixel_x(x_b), .pixel_y(y_b), .frame_start(fs_b)
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .TICK_DIV(2)
    ) u_dut_c (
        .clk(clk), .rst(rst), .p_tick(pt_c), .hsync(hs_c), .vsync(vs_c),
        .video_on(vo_c), .pixel_x(x_c), .pixel_y(y_c), .frame_start(fs_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {hsync, vsync, video_on, frame_start} for a coordinate pair
    function automatic logic [3:0] dec(int x, int y, int hd, int hf, int hs, int vd, int vf, int vs);
        logic hs_n, vs_n, vo, fs;
        hs_n = !((x >= hd + hf) && (x <= hd + hf + hs - 1));
        vs_n = !((y >= vd + vf) && (y <= vd + vf + vs - 1));
        vo   = (x < hd) && (y < vd);
        fs   = (x == 0) && (y == 0);
        return {hs_n, vs_n, vo, fs};
    endfunction

    // Expected outputs after the k-th clk edge since reset release.
    function automatic obs_t model(int k, int td, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        int   ht, vt, ticks, p, x, y;
        obs_t o;
        ht    = hd + hf + hs + hb;
        vt    = vd + vf + vs + vb;
        ticks = k / td;
        if (ticks == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            p = (ticks - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
        end
        o.x    = x[9:0];
        o.y    = y[9:0];
        {o.hs, o.vs, o.vo, o.fs} = dec(x, y, hd, hf, hs, vd, vf, vs);
        o.tick = ((k % td) == td - 1);
        return o;
    endfunction

    int   k;
    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];
    obs_t e_a, e_b, e_c;

    always @(posedge clk) begin
        if (!rst) k = 0;
        else      k = k + 1;
        q_a.push_back(model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q_b.push_back(model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        q_c.push_back(model(k, 2, 8, 2, 3, 2, 6, 1, 2, 1));
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            e_b = q_b.pop_front();
            e_c = q_c.pop_front();
            if (!rst) begin
                e_a = model(0, 4, 640, 16, 96, 48, 480, 10, 2, 33);
                e_b = model(0, 1, 640, 16, 96, 48, 480, 10, 2, 33);
                e_c = model(0, 2, 8, 2, 3, 2, 6, 1, 2, 1);
            end
            check_eq("sb_a", {pt_a, hs_a, vs_a, vo_a, fs_a, x_a, y_a}, e_a);
            check_eq("sb_b", {pt_b, hs_b, vs_b, vo_b, fs_b, x_b, y_b}, e_b);
            check_eq("sb_c", {pt_c, hs_c, vs_c, vo_c, fs_c, x_c, y_c}, e_c);
            check_eq("coh_a", {hs_a, vs_a, vo_a, fs_a}, dec(int'(x_a), int'(y_a), 640, 16, 96, 480, 10, 2));
            check_eq("coh_c", {hs_c, vs_c, vo_c, fs_c}, dec(int'(x_c), int'(y_c), 8, 2, 3, 6, 1, 2));
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   lo;
        int   xfall;
        bit   found;
        logic prev;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (x_a == 10'd0 && y_a == 10'd0) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("a_origin_seen", found, 1);

        cnt   = 0;
        xfall = -1;
        prev  = vo_a;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (!hs_a) cnt++;
            if (prev && !vo_a && xfall < 0) xfall = int'(x_a);
            prev = vo_a;
        end
        check_eq("a_hsync_low_clks", cnt, 384);
        check_eq("a_video_off_x", xfall, 640);
        check_eq("a_line_wrap_xy", {x_a, y_a}, {10'd0, 10'd1});

        found = 1'b0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (x_a == 10'd300) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("a_reach_x300", found, 1);
        #2 rst = 1'b0;
        #1 check_eq("a_async_reset", {pt_a, hs_a, vs_a, vo_a, fs_a, x_a, y_a},
                    {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd799, 10'd524});
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (fs_a) break;
        end
        check_eq("a_restart_edges", cnt, 4);
        check_eq("a_restart_origin", {vo_a, x_a, y_a}, {1'b1, 10'd0, 10'd0});

        found = 1'b0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (x_b == 10'd0) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("b_x0_seen", found, 1);
        cnt = 0;
        lo  = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            cnt++;
            if (!pt_b) lo++;
            if (x_b == 10'd0) break;
        end
        check_eq("b_line_clks", cnt, 800);
        check_eq("b_tick_low_clks", lo, 0);

        found = 1'b0;
        prev  = fs_c;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!prev && fs_c) begin
                found = 1'b1;
                break;
            end
            prev = fs_c;
        end
        check_eq("c_frame_start_seen", found, 1);
        cnt  = 0;
        prev = fs_c;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cnt++;
            if (!prev && fs_c) break;
            prev = fs_c;
        end
        check_eq("c_frame_clks", cnt, 300);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!vs_c) cnt++;
        end
        check_eq("c_vsync_low_clks", cnt, 60);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
